// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline control FSM encoding and the hard-wired zero register.
package cpu_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard inputs and stage-control outputs of the hazard/stall controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             ifid_use_rt_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic             redirect_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_stall_o;
  logic             idex_bubble_o;
  logic             exmem_stall_o;
  logic             err_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Pipeline datapath side.
  modport master (
    output ifid_rs_i, ifid_rt_i, ifid_use_rt_i, idex_memread_i, idex_rt_i,
           redirect_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_stall_o, idex_bubble_o,
           exmem_stall_o, err_timeout_o, stall_cnt_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  ifid_rs_i, ifid_rt_i, ifid_use_rt_i, idex_memread_i, idex_rt_i,
           redirect_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_stall_o, idex_bubble_o,
           exmem_stall_o, err_timeout_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_stall_ctrl_detect.sv
// Load-use hazard compare between the load in ID/EX and the instruction in IF/ID.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_use_rt,
  output logic       lu
);

  // A load into the zero register never creates a dependency.
  assign lu = idex_memread && (idex_rt != REG_ZERO) &&
              ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use bubbles, redirect flushes, data-memory wait holds and
// saturating stall/flush performance counters.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_ctrl_if.slave  ctl
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic lu;
  logic mem_miss;
  logic pc_write, ifid_write, ifid_flush, idex_stall, idex_bubble, exmem_stall, err_timeout;
  logic take_flush;

  hazard_detect u_detect (
    .idex_memread (ctl.idex_memread_i),
    .idex_rt      (ctl.idex_rt_i),
    .ifid_rs      (ctl.ifid_rs_i),
    .ifid_rt      (ctl.ifid_rt_i),
    .ifid_use_rt  (ctl.ifid_use_rt_i),
    .lu           (lu)
  );

  assign mem_miss = ctl.mem_req_i && !ctl.mem_ack_i;

  // Outputs decode straight from state and inputs so a hazard acts in the cycle it appears;
  // rst_i is folded in so the controls drop the moment reset is asserted.
  always_comb begin
    // NOTE: every output gets a default before the decode so no path can infer a latch.
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    exmem_stall = 1'b0;
    err_timeout = 1'b0;
    take_flush  = 1'b0;
    if (!rst_i) begin
      if (state == ST_MEM_WAIT || mem_miss) begin
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        err_timeout = (state == ST_MEM_WAIT) && !ctl.mem_ack_i && (wait_cnt == WAIT_LAST);
      end else if (lu) begin
        idex_bubble = 1'b1;
      end else if (ctl.redirect_i) begin
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
        take_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every register samples
  // the same pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (mem_miss) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (ctl.mem_ack_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (take_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign ctl.pc_write_o    = pc_write;
  assign ctl.ifid_write_o  = ifid_write;
  assign ctl.ifid_flush_o  = ifid_flush;
  assign ctl.idex_stall_o  = idex_stall;
  assign ctl.idex_bubble_o = idex_bubble;
  assign ctl.exmem_stall_o = exmem_stall;
  assign ctl.err_timeout_o = err_timeout;
  assign ctl.stall_cnt_o   = stall_cnt;
  assign ctl.flush_cnt_o   = flush_cnt;

endmodule
